// File: rtl/div_sched_if.sv
// Bundles the request, response and divider-side signals of the divider scheduler.
// slave is the scheduler's view; master is the view of whatever surrounds it.
interface div_sched_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             req0_valid;
    logic             req0_ready;
    logic             req0_signed;
    logic             req0_mod;
    logic [XLEN-1:0]  req0_a;
    logic [XLEN-1:0]  req0_b;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic             req1_signed;
    logic             req1_mod;
    logic [XLEN-1:0]  req1_a;
    logic [XLEN-1:0]  req1_b;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [XLEN-1:0]  rsp_result;
    logic             rsp_dbz;

    logic             div_start;
    logic             div_signed;
    logic [XLEN-1:0]  div_dividend;
    logic [XLEN-1:0]  div_divisor;
    logic             div_busy;
    logic             div_done;
    logic             div_dbz;
    logic [XLEN-1:0]  div_quotient;
    logic [XLEN-1:0]  div_remainder;

    modport slave (
        input  req0_valid, req0_signed, req0_mod, req0_a, req0_b, req0_tag,
        output req0_ready,
        input  req1_valid, req1_signed, req1_mod, req1_a, req1_b, req1_tag,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_dbz,
        input  rsp_ready,
        output div_start, div_signed, div_dividend, div_divisor,
        input  div_busy, div_done, div_dbz, div_quotient, div_remainder
    );

    modport master (
        output req0_valid, req0_signed, req0_mod, req0_a, req0_b, req0_tag,
        input  req0_ready,
        output req1_valid, req1_signed, req1_mod, req1_a, req1_b, req1_tag,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_dbz,
        output rsp_ready,
        input  div_start, div_signed, div_dividend, div_divisor,
        output div_busy, div_done, div_dbz, div_quotient, div_remainder
    );
endinterface

// File: rtl/div_sched.sv
// Round-robin scheduler sharing one iterative divider between two requesters,
// with flush cancellation and draining of results that arrive after a cancel.
module div_sched #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    output logic       idle,
    div_sched_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP,
        S_DRAIN
    } state_t;

    state_t           r_state;
    logic             r_lastId;
    logic             r_id;
    logic             r_signed;
    logic             r_mod;
    logic [XLEN-1:0]  r_a;
    logic [XLEN-1:0]  r_b;
    logic [TAG_W-1:0] r_tag;
    logic [XLEN-1:0]  r_result;
    logic             r_dbz;
    logic             r_rspValid;
    logic             r_idle;

    logic             w_grant;
    logic             w_accept;
    logic             w_start;
    logic             w_selSigned;
    logic             w_selMod;
    logic [XLEN-1:0]  w_selA;
    logic [XLEN-1:0]  w_selB;
    logic [TAG_W-1:0] w_selTag;

    // On a tie the requester that did not win last time gets the grant.
    assign w_grant  = (bus.req0_valid && bus.req1_valid) ? ~r_lastId : bus.req1_valid;
    assign w_accept = (r_state == S_IDLE) && !flush &&
                      (w_grant ? bus.req1_valid : bus.req0_valid);
    assign w_start  = (r_state == S_ISSUE) && !flush && !bus.div_busy;

    assign w_selSigned = w_grant ? bus.req1_signed : bus.req0_signed;
    assign w_selMod    = w_grant ? bus.req1_mod    : bus.req0_mod;
    assign w_selA      = w_grant ? bus.req1_a      : bus.req0_a;
    assign w_selB      = w_grant ? bus.req1_b      : bus.req0_b;
    assign w_selTag    = w_grant ? bus.req1_tag    : bus.req0_tag;

    assign bus.req0_ready   = (r_state == S_IDLE) && !flush && !w_grant;
    assign bus.req1_ready   = (r_state == S_IDLE) && !flush &&  w_grant;
    assign bus.rsp_valid    = r_rspValid;
    assign bus.rsp_id       = r_id;
    assign bus.rsp_tag      = r_tag;
    assign bus.rsp_result   = r_result;
    assign bus.rsp_dbz      = r_dbz;
    assign bus.div_start    = w_start;
    assign bus.div_signed   = r_signed;
    assign bus.div_dividend = r_a;
    assign bus.div_divisor  = r_b;
    assign idle             = r_idle;

    // Flush overrides every transition; a busy divider left over from a
    // cancelled or reset operation holds us in ISSUE until it frees up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_lastId   <= 1'b1;
            r_id       <= 1'b0;
            r_signed   <= 1'b0;
            r_mod      <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_tag      <= '0;
            r_result   <= '0;
            r_dbz      <= 1'b0;
            r_rspValid <= 1'b0;
            r_idle     <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_lastId <= w_grant;
                        r_id     <= w_grant;
                        r_signed <= w_selSigned;
                        r_mod    <= w_selMod;
                        r_a      <= w_selA;
                        r_b      <= w_selB;
                        r_tag    <= w_selTag;
                        r_state  <= S_ISSUE;
                        r_idle   <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_idle  <= 1'b1;
                    end else if (!bus.div_busy) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.div_done) begin
                        if (flush) begin
                            r_state <= S_IDLE;
                            r_idle  <= 1'b1;
                        end else begin
                            r_result   <= r_mod ? bus.div_remainder : bus.div_quotient;
                            r_dbz      <= bus.div_dbz;
                            r_rspValid <= 1'b1;
                            r_state    <= S_RESP;
                        end
                    end else if (flush) begin
                        r_state <= S_DRAIN;
                    end
                end
                S_RESP: begin
                    if (flush || bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_state    <= S_IDLE;
                        r_idle     <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (bus.div_done) begin
                        r_state <= S_IDLE;
                        r_idle  <= 1'b1;
                    end
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_state    <= S_IDLE;
                    r_idle     <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_sched.sv
// Scoreboard bench for div_sched with a behavioural 32-cycle divider model;
// expected responses are queued at accept and popped on each response handshake.
module tb_div_sched;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;

    typedef struct {
        logic             id;
        logic [TAG_W-1:0] tag;
        logic [XLEN-1:0]  result;
        logic             dbz;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;
    logic idle;

    div_sched_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus();

    div_sched #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .idle  (idle),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t expQ[$];
    exp_t monE;
    int nChecks = 0;
    int nPass = 0;
    int cyc = 0;
    int startCount = 0;
    int divCnt = 0;
    logic [XLEN-1:0] dA, dB, dQ, dR;
    logic dSigned;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        nChecks++;
        if (act === req) nPass++;
        else $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    endtask

    // Divider model: done arrives 33 cycles after start, or 1 cycle for a zero divisor.
    always @(negedge clk) begin
        bus.div_done = 1'b0;
        if (divCnt > 0) begin
            divCnt--;
            if (divCnt == 0) begin
                bus.div_done = 1'b1;
                bus.div_dbz  = (dB == 0);
                if (dB == 0) begin
                    dQ = '0;
                    dR = dA;
                end else if (dSigned) begin
                    dQ = $signed(dA) / $signed(dB);
                    dR = $signed(dA) % $signed(dB);
                end else begin
                    dQ = dA / dB;
                    dR = dA % dB;
                end
                bus.div_quotient  = dQ;
                bus.div_remainder = dR;
            end
        end
        bus.div_busy = (divCnt > 0) || bus.div_done;
        #2;
        if (bus.div_start) begin
            startCount++;
            dA      = bus.div_dividend;
            dB      = bus.div_divisor;
            dSigned = bus.div_signed;
            divCnt  = (bus.div_divisor == 0) ? 1 : 33;
        end
    end

    // Monitor: every completed response handshake must match the oldest expectation.
    always @(negedge clk) begin
        #1;
        if (!reset && bus.rsp_valid && bus.rsp_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 64'(1), 64'(0));
            end else begin
                monE = expQ.pop_front();
                checkOutput("rspId", 64'(bus.rsp_id), 64'(monE.id));
                checkOutput("rspTag", 64'(bus.rsp_tag), 64'(monE.tag));
                checkOutput("rspResult", 64'(bus.rsp_result), 64'(monE.result));
                checkOutput("rspDbz", 64'(bus.rsp_dbz), 64'(monE.dbz));
            end
        end
    end

    task automatic driveReq(input bit id, input bit sgn, input bit md,
                            input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                            input logic [TAG_W-1:0] tag);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_signed = sgn; bus.req1_mod = md;
            bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_signed = sgn; bus.req0_mod = md;
            bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag;
        end
    endtask

    task automatic applyStimulus(input bit id, input bit sgn, input bit md,
                                 input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                 input logic [TAG_W-1:0] tag, input bit expectRsp,
                                 input logic [XLEN-1:0] expResult, input bit expDbz,
                                 output int acceptCyc);
        @(negedge clk);
        driveReq(id, sgn, md, a, b, tag);
        acceptCyc = -1;
        for (int k = 0; k < 200; k++) begin
            #1;
            if (id ? bus.req1_ready : bus.req0_ready) begin
                acceptCyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (acceptCyc < 0) checkOutput("acceptTimeout", 64'(1), 64'(0));
        else if (expectRsp) expQ.push_back('{id, tag, expResult, expDbz});
        @(negedge clk);
        if (id) bus.req1_valid = 1'b0;
        else    bus.req0_valid = 1'b0;
    endtask

    task automatic waitRsp(output int rspCyc);
        rspCyc = -1;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            if (bus.rsp_valid) begin
                rspCyc = cyc;
                break;
            end
        end
        if (rspCyc < 0) checkOutput("rspTimeout", 64'(1), 64'(0));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t, r, acc, prevAcc, s0, bad, gid;
        logic [63:0] snap;
        bus.req0_valid = 0; bus.req0_signed = 0; bus.req0_mod = 0;
        bus.req0_a = 0; bus.req0_b = 0; bus.req0_tag = 0;
        bus.req1_valid = 0; bus.req1_signed = 0; bus.req1_mod = 0;
        bus.req1_a = 0; bus.req1_b = 0; bus.req1_tag = 0;
        bus.rsp_ready = 1; bus.div_busy = 0; bus.div_done = 0; bus.div_dbz = 0;
        bus.div_quotient = 0; bus.div_remainder = 0;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("resetIdle", 64'(idle), 64'(1));
        checkOutput("resetRspValid", 64'(bus.rsp_valid), 64'(0));
        checkOutput("resetDivStart", 64'(bus.div_start), 64'(0));
        checkOutput("resetRspData", {bus.rsp_result, 27'(bus.rsp_tag), bus.rsp_id, bus.rsp_dbz}, 64'(0));
        checkOutput("resetOperands", {bus.div_dividend, bus.div_divisor}, 64'(0));
        @(negedge clk);
        reset = 0;

        // Basic unsigned quotient with latency checks.
        applyStimulus(0, 0, 0, 100, 7, 3, 1, 14, 0, t);
        #1;
        checkOutput("startAtT1", 64'(bus.div_start), 64'(1));
        checkOutput("operandsAtT1", {bus.div_dividend, bus.div_divisor}, {32'd100, 32'd7});
        waitRsp(r);
        checkOutput("latencyNormal", 64'(r - t), 64'(35));

        // Signed remainder and quotient on requester 1; back-to-back accept after handshake.
        applyStimulus(1, 1, 1, 32'hFFFF_FFF9, 2, 9, 1, 32'hFFFF_FFFF, 0, t);
        checkOutput("rspToAccept", 64'(t - r), 64'(1));
        waitRsp(r);
        applyStimulus(1, 1, 0, 32'hFFFF_FFF9, 2, 10, 1, 32'hFFFF_FFFD, 0, t);
        waitRsp(r);

        // Both requesters valid continuously: grants alternate starting with 0.
        @(negedge clk);
        driveReq(0, 0, 0, 50, 5, 1);
        driveReq(1, 0, 1, 50, 8, 2);
        prevAcc = -1;
        for (int n = 0; n < 4; n++) begin
            acc = -1;
            for (int k = 0; k < 100; k++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) begin
                    acc = cyc;
                    gid = bus.req1_ready ? 1 : 0;
                    checkOutput("grantOrder", 64'(gid), 64'(n % 2));
                    if (gid == 1) expQ.push_back('{1'b1, 5'd2, 32'd2, 1'b0});
                    else          expQ.push_back('{1'b0, 5'd1, 32'd10, 1'b0});
                    if (prevAcc >= 0) checkOutput("throughput", 64'(acc - prevAcc), 64'(36));
                    prevAcc = acc;
                    @(negedge clk);
                    break;
                end
                @(negedge clk);
            end
            if (acc < 0) checkOutput("alternateTimeout", 64'(1), 64'(0));
        end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        waitRsp(r);

        // Divide by zero: single start pulse, short latency, pass-through results.
        s0 = startCount;
        applyStimulus(0, 0, 0, 32'h1234, 0, 12, 1, 0, 1, t);
        waitRsp(r);
        checkOutput("latencyDbz", 64'(r - t), 64'(3));
        checkOutput("dbzStartPulses", 64'(startCount - s0), 64'(1));
        applyStimulus(0, 0, 1, 32'h1234, 0, 13, 1, 32'h1234, 1, t);
        waitRsp(r);

        // Flush in WAIT: drain the late result, no response, ready held low until done.
        applyStimulus(0, 0, 0, 500, 7, 5, 0, 0, 0, t);
        repeat (9) @(negedge clk);
        flush = 1;
        driveReq(0, 0, 1, 1003, 10, 7);
        @(negedge clk);
        flush = 0;
        bad = 0;
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            #1;
            if (bus.rsp_valid) bad++;
            if (bus.req0_ready) begin
                acc = cyc;
                break;
            end
            @(negedge clk);
        end
        checkOutput("drainNoRsp", 64'(bad), 64'(0));
        checkOutput("drainRelease", 64'(acc - t), 64'(35));
        if (acc >= 0) expQ.push_back('{1'b0, 5'd7, 32'd3, 1'b0});
        @(negedge clk);
        bus.req0_valid = 0;
        waitRsp(r);
        checkOutput("latencyAfterDrain", 64'(r - acc), 64'(35));

        // Backpressure: response fields stay stable while rsp_ready is low.
        @(negedge clk);
        bus.rsp_ready = 0;
        applyStimulus(1, 0, 0, 20, 3, 4, 1, 6, 0, t);
        waitRsp(r);
        snap = {bus.rsp_result, 26'(bus.rsp_tag), bus.rsp_id, bus.rsp_dbz, 4'h0};
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            if (!bus.rsp_valid ||
                snap != {bus.rsp_result, 26'(bus.rsp_tag), bus.rsp_id, bus.rsp_dbz, 4'h0}) bad++;
        end
        checkOutput("holdStable", 64'(bad), 64'(0));
        @(negedge clk);
        bus.rsp_ready = 1;
        @(negedge clk);
        #1;
        checkOutput("rspReleased", 64'(bus.rsp_valid), 64'(0));

        // Flush in RESP drops the response.
        bus.rsp_ready = 0;
        applyStimulus(0, 0, 0, 9, 3, 6, 0, 0, 0, t);
        waitRsp(r);
        @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        #1;
        checkOutput("flushRespDrop", 64'(bus.rsp_valid), 64'(0));
        checkOutput("flushRespIdle", 64'(idle), 64'(1));
        bus.rsp_ready = 1;

        // Reset mid-WAIT, then the first tie after reset goes to requester 0.
        applyStimulus(1, 0, 0, 77, 7, 8, 0, 0, 0, t);
        repeat (4) @(negedge clk);
        reset = 1;
        #1;
        checkOutput("resetMidIdle", 64'(idle), 64'(1));
        checkOutput("resetMidOutputs", {bus.div_dividend, 30'(0), bus.rsp_valid, bus.div_start}, 64'(0));
        @(negedge clk);
        reset = 0;
        @(negedge clk);
        driveReq(0, 0, 0, 81, 9, 11);
        driveReq(1, 0, 0, 64, 4, 14);
        #1;
        checkOutput("tieAfterReset", {62'(0), bus.req1_ready, bus.req0_ready}, 64'(1));
        if (bus.req0_ready) expQ.push_back('{1'b0, 5'd11, 32'd9, 1'b0});
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        waitRsp(r);

        repeat (3) @(negedge clk);
        checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'(0));
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end
endmodule

// File: doc/div_sched.md
# div_sched

Round-robin scheduler that shares one iterative divider between two requesters, such as the EX-stage integer divide path and a second issue port. It arbitrates requests and sequences the divider's start/done protocol. It returns quotient or remainder, with the originating requester ID and tag, over a single backpressured response port. A pipeline flush cancels the in-flight operation; any late divider result is then drained and discarded.

## Interface
- XLEN, 32: operand/result width.
- TAG_W, 5: requester tag width.

- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  cancel any accepted/in-flight operation.
- reqN_valid (N=0,1)  in  1  request N valid.
- reqN_ready  out  1  request N accepted when valid&ready.
- reqN_signed  in  1  signed operation.
- reqN_mod  in  1  1 = return remainder, 0 = return quotient.
- reqN_a  in  XLEN  dividend.
- reqN_b  in  XLEN  divisor.
- reqN_tag  in  TAG_W  opaque tag, echoed on response.
- rsp_valid  out  1  response valid; held until rsp_ready.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of response.
- rsp_tag  out  TAG_W  echoed tag.
- rsp_result  out  XLEN  quotient or remainder per latched mod bit.
- rsp_dbz  out  1  divisor was zero.
- div_start  out  1  one-cycle start pulse to divider.
- div_signed  out  1  signed mode to divider.
- div_dividend, div_divisor  out  XLEN  operands to divider, stable from accept until done.
- div_busy  in  1  divider busy.
- div_done  in  1  divider one-cycle completion pulse.
- div_dbz  in  1  divider divide-by-zero flag, valid with div_done.
- div_quotient, div_remainder  in  XLEN  divider results, valid with div_done.
- idle  out  1  FSM in IDLE.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - ISSUE: asserts div_start.
  - WAIT: waits for div_done.
  - RESP: holds the response.
  - DRAIN: discards a cancelled result.
- Arbitration: reqN_ready = (state==IDLE) & !flush & grant==N.
  - grant = the sole valid requester; if both are valid, grant = ~last_id.
  - last_id updates to N on accept.
  - Requesters must not depend on ready before asserting valid.
- Accept: latch signed, mod, a, b, tag and id into registers, then IDLE -> ISSUE. The div_* operand outputs are driven from these registers.
- ISSUE: div_start = 1 only if !flush and !div_busy; then -> WAIT.
  - If div_busy=1 (stale op after a cancel), stay in ISSUE with start low.
- WAIT: on div_done, capture result = mod ? div_remainder : div_quotient, and rsp_dbz = div_dbz; -> RESP.
- RESP: rsp_valid=1 with all rsp_* fields held stable; rsp_valid&rsp_ready -> IDLE.
- Divide-by-zero: no special handling. Results pass through from the divider (quotient 0, remainder = dividend), with rsp_dbz=1.
- Flush priority is absolute:
  - IDLE: no accept that cycle.
  - ISSUE: div_start suppressed; -> IDLE.
  - WAIT without div_done: -> DRAIN.
  - WAIT with div_done in the same cycle: result discarded; -> IDLE.
  - RESP: response dropped even if rsp_ready=1; -> IDLE.
  - DRAIN: no effect.
- DRAIN: reqN_ready=0; on div_done -> IDLE, no response.
- div_done while in IDLE or RESP is ignored.

## Timing
- Reset values:
  - State IDLE, last_id=1 (req0 wins the first tie).
  - rsp_valid=0, div_start=0, idle=1.
  - All rsp_* data and div_* operand outputs 0.
- Accept in cycle T:
  - div_start high in T+1.
  - With the 32-cycle divider: div_done in T+34, rsp_valid in T+35.
  - Divide-by-zero: div_done in T+2, rsp_valid in T+3.
- Response-to-next-accept: a handshake in cycle R gives IDLE in R+1, and a new accept is possible in R+1.
- Sustained throughput: one operation per (divider latency + 3) cycles with rsp_ready=1.
- Reset asserted mid-operation: immediate return to IDLE with outputs at reset values. Any later stray div_done is ignored.

## Test plan
- req0: a=100, b=7, unsigned, mod=0, tag=3 -> rsp_valid at T+35, rsp_result=14, rsp_id=0, rsp_tag=3, rsp_dbz=0.
- req1: a=-7 (0xFFFFFFF9), b=2, signed, mod=1 -> rsp_result=0xFFFFFFFF (-1); same with mod=0 -> 0xFFFFFFFD (-3).
- req0 and req1 both valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1; each response id matches its request.
- req0: b=0, a=0x1234 -> div_start once, rsp_valid at T+3, rsp_dbz=1, quotient path 0, mod path 0x1234.
- Flush 10 cycles after accept -> DRAIN, no rsp_valid; reqN_ready stays 0 until div_done; the next request completes correctly.
- rsp_ready held 0 for 5 cycles after rsp_valid -> rsp_* stable; flush during RESP -> rsp_valid drops next cycle; reset asserted mid-WAIT -> idle=1 immediately.
